// File: rtl/sr_pkg.sv
// sr_pkg: shared FSM state type and default parameters for the SR command conditioner
package sr_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} sr_state_t;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int GAP_DEF = 2;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/sr_debounce.sv
// sr_debounce: 2-flop synchroniser, stable-count debouncer and rising-edge pulse
module sr_debounce
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic clear,
  input  logic raw,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level;
  // level flips after DEB_CYCLES consecutive mismatching samples; rise marks a 0->1 flip
  always_ff @(posedge clk)
    if (clear) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        level <= ~level;
        rise <= ~level;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounced set/reset requests to spaced, never-overlapping s/r pulses; SR_CONFLICT_CNT_EN enables the conflict counter
module sr_cmd_gen
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int GAP = GAP_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic clear,
  input  logic set_raw,
  input  logic rst_raw,
  output logic s,
  output logic r,
  output logic busy,
  output logic shadow_q,
  output logic [CNT_W-1:0] conflict_cnt
);
  localparam int HW = $clog2(GAP + 2);
  sr_state_t state, state_n;
  logic set_rise, rst_rise, set_pend, rst_pend, set_eff, rst_eff, idle, s_n, r_n;
  logic [HW-1:0] hcnt, hcnt_n;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set (.clk(clk), .clear(clear), .raw(set_raw), .rise(set_rise));
  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rst (.clk(clk), .clear(clear), .raw(rst_raw), .rise(rst_rise));

  assign set_eff = set_pend | set_rise;
  assign rst_eff = rst_pend | rst_rise;
  assign idle = state == IDLE;
  assign busy = !idle;

  // next state: serve a lone request from IDLE, then one pulse cycle and GAP holdoff cycles
  always_comb begin
    state_n = state;
    hcnt_n = hcnt;
    s_n = 1'b0;
    r_n = 1'b0;
    unique case (state)
      IDLE: if (set_eff ^ rst_eff) begin
        state_n = PULSE;
        s_n = set_eff;
        r_n = rst_eff;
      end
      PULSE: begin
        state_n = GAP > 0 ? HOLDOFF : IDLE;
        hcnt_n = HW'(GAP > 0 ? GAP - 1 : 0);
      end
      HOLDOFF: begin
        state_n = hcnt == '0 ? IDLE : HOLDOFF;
        hcnt_n = hcnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // state, pulses, shadow q and pending flags; IDLE consumes every effective request
  always_ff @(posedge clk)
    if (clear) begin
      state <= IDLE;
      hcnt <= '0;
      s <= 1'b0;
      r <= 1'b0;
      shadow_q <= 1'b0;
      set_pend <= 1'b0;
      rst_pend <= 1'b0;
    end else begin
      state <= state_n;
      hcnt <= hcnt_n;
      s <= s_n;
      r <= r_n;
      shadow_q <= s_n ? 1'b1 : r_n ? 1'b0 : shadow_q;
      set_pend <= idle ? 1'b0 : set_eff;
      rst_pend <= idle ? 1'b0 : rst_eff;
    end

`ifdef SR_CONFLICT_CNT_EN
  // saturating count of simultaneous requests dropped in IDLE
  always_ff @(posedge clk)
    if (clear) conflict_cnt <= '0;
    else if (idle && set_eff && rst_eff && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
`else
  assign conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: directed test-plan scenarios plus random bouncy stimulus against a behavioural model
module tb_sr_cmd_gen;
  localparam int DEB = 4;
  localparam int GAP = 2;
  localparam int CNT_W = 8;
  localparam int CMAX = (1 << CNT_W) - 1;
`ifdef SR_CONFLICT_CNT_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  logic clk = 1'b0, clear = 1'b1, set_raw = 1'b0, rst_raw = 1'b0;
  logic s, r, busy, shadow_q;
  logic [CNT_W-1:0] conflict_cnt;
  int pass_n = 0, tot_n = 0;
  bit hs[$], hr[$];
  bit m_lvl_s, m_lvl_r, m_rise_s, m_rise_r, m_pend_s, m_pend_r, m_s, m_r, m_shadow;
  int m_wait, m_cnt;

  sr_cmd_gen #(.DEB_CYCLES(DEB), .GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .clear(clear), .set_raw(set_raw), .rst_raw(rst_raw),
    .s(s), .r(r), .busy(busy), .shadow_q(shadow_q), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    hs.delete();
    hr.delete();
    repeat (DEB + 2) begin
      hs.push_back(1'b0);
      hr.push_back(1'b0);
    end
    {m_lvl_s, m_lvl_r, m_rise_s, m_rise_r, m_pend_s, m_pend_r, m_s, m_r, m_shadow} = '0;
    m_wait = 0;
    m_cnt = 0;
  endtask

  function automatic void deb(input bit h[$], inout bit lvl, output bit rise);
    bit v, same;
    v = h[h.size() - 3];
    same = 1'b1;
    for (int j = 0; j < DEB; j++) if (h[h.size() - 3 - j] != v) same = 1'b0;
    rise = 1'b0;
    if (same && v != lvl) begin
      lvl = v;
      rise = v;
    end
  endfunction

  task automatic tick();
    bit se, re;
    @(posedge clk);
    if (clear) model_reset();
    else begin
      se = m_pend_s | m_rise_s;
      re = m_pend_r | m_rise_r;
      m_s = 1'b0;
      m_r = 1'b0;
      if (m_wait == 0) begin
        if (se && !re) begin m_s = 1'b1; m_shadow = 1'b1; m_wait = GAP + 1; end
        else if (re && !se) begin m_r = 1'b1; m_shadow = 1'b0; m_wait = GAP + 1; end
        else if (se && re && m_cnt < CMAX) m_cnt++;
        m_pend_s = 1'b0;
        m_pend_r = 1'b0;
      end else begin
        m_wait--;
        m_pend_s = se;
        m_pend_r = re;
      end
      hs.push_back(set_raw);
      hr.push_back(rst_raw);
      if (hs.size() > DEB + 4) begin
        void'(hs.pop_front());
        void'(hr.pop_front());
      end
      deb(hs, m_lvl_s, m_rise_s);
      deb(hr, m_lvl_r, m_rise_r);
    end
    #1;
    chk("s", 32'(s), 32'(m_s));
    chk("r", 32'(r), 32'(m_r));
    chk("busy", 32'(busy), 32'(m_wait > 0));
    chk("shadow_q", 32'(shadow_q), 32'(m_shadow));
    chk("conflict_cnt", 32'(conflict_cnt), CEN ? 32'(m_cnt) : 32'd0);
    chk("sr_both_high", 32'(s & r), 32'd0);
  endtask

  task automatic idle_n(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int lat, sn, bn, pulses, ta, tb, rs, rr;
    model_reset();
    idle_n(2);
    chk("rst_outs", 32'({s, r, busy, shadow_q}), 32'd0);
    clear = 1'b0;
    idle_n(3);

    set_raw = 1'b1;
    lat = -1; sn = 0; bn = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (s && lat < 0) lat = e;
      sn += int'(s);
      bn += int'(busy);
    end
    chk("lat_s", 32'(lat), 32'(DEB + 2));
    chk("s_width", 32'(sn), 32'd1);
    chk("busy_len", 32'(bn), 32'(GAP + 1));
    chk("shadow_set", 32'(shadow_q), 32'd1);

    set_raw = 1'b0;
    idle_n(10);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      set_raw = (i % 4) < 2;
      tick();
      pulses += int'(s | r);
    end
    set_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); pulses += int'(s | r); end
    chk("bounce_pulses", 32'(pulses), 32'd0);

    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      set_raw = 1'b1; rst_raw = 1'b1;
      for (int i = 0; i < 10; i++) begin tick(); pulses += int'(s | r); end
      if (k == 0) chk("conf_first", 32'(conflict_cnt), CEN ? 32'd1 : 32'd0);
      set_raw = 1'b0; rst_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin tick(); pulses += int'(s | r); end
    end
    chk("conf_pulses", 32'(pulses), 32'd0);
    chk("conf_sat", 32'(conflict_cnt), CEN ? 32'(CMAX) : 32'd0);

    set_raw = 1'b1;
    ta = -1; tb = -1;
    for (int e = 0; e < 30; e++) begin
      if (e == 2) rst_raw = 1'b1;
      tick();
      if (s && ta < 0) ta = e;
      if (r && tb < 0) tb = e;
    end
    chk("gap_s_seen", 32'(ta >= 0), 32'd1);
    chk("gap_low", 32'(tb - ta - 1), 32'(GAP + 1));
    chk("shadow_reset", 32'(shadow_q), 32'd0);
    set_raw = 1'b0; rst_raw = 1'b0;
    idle_n(12);

    set_raw = 1'b1;
    lat = -1;
    for (int e = 0; e < 20 && lat < 0; e++) begin
      tick();
      if (s) lat = e;
    end
    chk("clr_pre_s", 32'(lat), 32'(DEB + 2));
    clear = 1'b1;
    tick();
    chk("clr_outs", 32'({s, r, busy, shadow_q}), 32'd0);
    chk("clr_cnt", 32'(conflict_cnt), 32'd0);
    clear = 1'b0;
    lat = -1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (s && lat < 0) lat = e;
    end
    chk("clr_relat", 32'(lat), 32'(DEB + 2));
    set_raw = 1'b0;
    idle_n(10);

    rs = 0; rr = 0;
    repeat (4000) begin
      if (rs == 0) begin set_raw = 1'($urandom_range(0, 1)); rs = $urandom_range(1, 9); end
      if (rr == 0) begin rst_raw = 1'($urandom_range(0, 1)); rr = $urandom_range(1, 9); end
      rs--; rr--;
      if ($urandom_range(0, 59) == 0) begin
        set_raw = 1'b1; rst_raw = 1'b1; rs = 8; rr = 8;
      end
      clear = $urandom_range(0, 299) == 0;
      tick();
    end
    clear = 1'b0;
    idle_n(4);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Command conditioner sitting directly upstream of the team's SR flip-flop. Takes two raw, possibly bouncy set/reset request lines and synchronises and debounces them. Converts their rising edges into clean one-cycle `s`/`r` pulses with a guaranteed minimum gap, and never drives `s` and `r` high together. Also keeps a shadow copy of the flop's expected `q` and can count conflicting requests.

## Interface
Parameters:
- `DEB_CYCLES`, 4: consecutive stable cycles required before a debounced level changes; must be at least 1.
- `GAP`, 2: idle cycles forced after every emitted pulse; must be at least 0.
- `CNT_W`, 8: width of the conflict counter.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `clear`, input, 1: reset, synchronous and active-high.
- `set_raw`, input, 1: asynchronous, bouncy set request.
- `rst_raw`, input, 1: asynchronous, bouncy reset request.
- `s`, output, 1: set pulse to the SR flop; registered.
- `r`, output, 1: reset pulse to the SR flop; registered.
- `busy`, output, 1: high while the FSM is not in IDLE.
- `shadow_q`, output, 1: expected flop `q` after the last emitted pulse.
- `conflict_cnt`, output, CNT_W: saturating count of dropped simultaneous requests.

## Operation
- Each raw input passes through a 2-flop synchroniser and then a debouncer.
  - The debouncer's counter increments while the synchronised value differs from the debounced level, and clears when they match.
  - The level toggles when the count reaches DEB_CYCLES.
  - The debouncer emits a one-cycle `rise` pulse coincident with a 0→1 level toggle.
  - Falling edges produce nothing.
- Pending flags `set_pend` and `rst_pend`:
  - Set by `rise` in any state.
  - A `rise` on a flag that is already pending is merged: still a single request.
- FSM states: IDLE, PULSE, HOLDOFF.
- In IDLE, the effective requests are `pend | rise` for each side:
  - Set only: go to PULSE, `s`=1 next cycle, clear `set_pend`.
  - Reset only: go to PULSE, `r`=1 next cycle, clear `rst_pend`.
  - Both: conflict. Clear both pending flags, emit no pulse, increment `conflict_cnt` (saturating at all-ones), stay in IDLE.
  - Neither: stay in IDLE.
- PULSE lasts exactly one cycle, with `s` or `r` high.
  - `shadow_q` updates on the same edge that raises the pulse: 1 for set, 0 for reset.
  - Next state is HOLDOFF if GAP>0, else IDLE.
- HOLDOFF lasts GAP cycles, counted by a down-counter, then returns to IDLE.
  - Requests arriving during PULSE or HOLDOFF stay pending and are served in order on return to IDLE.
  - A set pending during a reset pulse is therefore legal; it is emitted after the gap.
- `{s,r}` == 2'b11 is never driven under any input sequence.

## Timing
- Reset values: `s`=0, `r`=0, `busy`=0, `shadow_q`=0 (matches the flop's cleared `q`), `conflict_cnt`=0, FSM=IDLE.
  - Synchroniser flops, debounced levels, counters and pending flags are all cleared.
- Latency: a raw rising edge that is clean and stable, first sampled on edge 0, raises `s` (or `r`) after edge DEB_CYCLES+2, provided the FSM is in IDLE. With defaults, that is edge 6.
- Pulse width is exactly 1 cycle.
- Minimum spacing between consecutive pulses is GAP+1 cycles low, measured from the falling edge of one pulse to the rising edge of the next.
- A bounce shorter than DEB_CYCLES cycles produces no pulse.
- `clear` asserted mid-operation:
  - Any pulse in flight drops on the next edge.
  - All pending requests are lost.
- A raw input held high across `clear` release is treated as a new rising edge: it re-debounces and then pulses.
- `clear` dominates all other inputs on the same edge.

## Configuration
- `SR_CONFLICT_CNT_EN` defined: the conflict counter is implemented as described.
- Not defined:
  - The counter register is removed and `conflict_cnt` is tied to 0.
  - Conflict arbitration is unchanged: both requests are still dropped.

## Structure
- Package `sr_pkg`:
  - Holds `sr_state_t`, an enum of IDLE, PULSE, HOLDOFF.
  - Holds default constants for DEB_CYCLES, GAP and CNT_W.
- Sub-module `sr_debounce`:
  - Contains the synchroniser, the stable counter, the level register and the `rise` pulse.
  - Instantiated twice: once for `set_raw`, once for `rst_raw`.
- Top level holds the pending flags, the FSM, the holdoff counter, the output registers, `shadow_q` and the counter.

## Test plan
- Clean `set_raw` 0→1 held high, with defaults: `s` high for one cycle after edge 6, `shadow_q`=1, `busy` high for 3 cycles.
- `set_raw` toggling every 2 cycles for 20 cycles, then low: no `s` or `r` pulse ever.
- `set_raw` and `rst_raw` rising on the same cycle: no pulse, and `conflict_cnt` goes 0→1. Repeat 300 times with CNT_W=8: the count saturates at 255. Without the macro, the count stays 0.
- `rst_raw` rising 2 cycles after `set_raw`: `s` pulse, then after the gap (GAP+1 cycles low) an `r` pulse. `shadow_q` ends at 0 and `{s,r}` is never 11.
- `clear` asserted one cycle after `s` rises: `s`=0 on the next edge and all outputs return to reset values. With `set_raw` still high, a new `s` pulse follows DEB_CYCLES+2 edges after `clear` release.
